// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing checker: default width,
// opcode encodings and the checker FSM state type.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  // Plain AND/OR/XOR/NOT clash with SV keywords, hence the OP_ prefix.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_e;

endpackage

// File: rtl/alu_seq_checker_if.sv
// Command, ALU-drive and response signals of the ALU sequencing checker.
// The checker attaches as slave; the host / ALU side attaches as master.
interface alu_seq_checker_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH,
  parameter int ERR_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_sel;
  logic             cmd_sweep;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic [2:0]       rsp_sel;
  logic             rsp_mismatch;
  logic             rsp_last;

  logic [ERR_W-1:0] err_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_sweep,
    input  alu_result, alu_carryout, alu_zero,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sel,
    output rsp_mismatch, rsp_last, err_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_sweep,
    output alu_result, alu_carryout, alu_zero,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sel,
    input  rsp_mismatch, rsp_last, err_count
  );

endinterface

// File: rtl/alu_ref_model.sv
// Purely combinational golden model of the 4-bit ALU; usable standalone
// by benches as well as inside the sequencing checker.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH:0] sum;

  // Carry doubles as borrow for SUB/DEC and as wrap flag for INC.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (sel)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_INC: begin
        result = a + ONE;
        carry  = &a;
      end
      OP_DEC: begin
        result = a - ONE;
        carry  = (a == '0);
      end
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_seq_checker.sv
// Drives an external ALU from registers, captures its outputs after a settle
// time, compares them with the golden model and returns them as a response.
module alu_seq_checker
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input logic              clk,
  input logic              rst,
  alu_seq_checker_if.slave bus
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       sel_q;
  logic             sweep_q;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_carry_q;
  logic             rsp_zero_q;
  logic [2:0]       rsp_sel_q;
  logic             rsp_mismatch_q;
  logic             rsp_last_q;
  logic [ERR_W-1:0] err_q;

  logic             cmd_fire;
  logic             rsp_fire;
  logic             settle_done;
  logic             sweep_more;
  logic [WIDTH-1:0] gold_result;
  logic             gold_carry;
  logic             gold_zero;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel_q),
    .result (gold_result),
    .carry  (gold_carry),
    .zero   (gold_zero)
  );

  // Ready is gated by rst so it reads 0 for the whole reset pulse.
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign cmd_fire      = bus.cmd_ready && bus.cmd_valid;
  assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
  assign settle_done   = (state == DRIVE) && (settle_cnt == SETTLE_LAST);
  assign sweep_more    = sweep_q && (sel_q != OP_DEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = DRIVE;
      DRIVE:   if (settle_done) state_next = RESP;
      RESP:    if (rsp_fire) state_next = sweep_more ? DRIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU drive registers only move on accept or on a sweep handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q            <= '0;
      b_q            <= '0;
      sel_q          <= '0;
      sweep_q        <= 1'b0;
      settle_cnt     <= '0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_sel_q      <= '0;
      rsp_mismatch_q <= 1'b0;
      rsp_last_q     <= 1'b0;
      err_q          <= '0;
    end else begin
      if (cmd_fire) begin
        a_q        <= bus.cmd_a;
        b_q        <= bus.cmd_b;
        sweep_q    <= bus.cmd_sweep;
        sel_q      <= bus.cmd_sweep ? OP_ADD : bus.cmd_sel;
        settle_cnt <= '0;
      end else if (rsp_fire && sweep_more) begin
        sel_q      <= sel_q + 3'd1;
        settle_cnt <= '0;
      end else if ((state == DRIVE) && !settle_done) begin
        settle_cnt <= settle_cnt + 4'd1;
      end

      if (settle_done) begin
        rsp_result_q   <= bus.alu_result;
        rsp_carry_q    <= bus.alu_carryout;
        rsp_zero_q     <= bus.alu_zero;
        rsp_sel_q      <= sel_q;
        rsp_mismatch_q <= (bus.alu_result != gold_result) ||
                          (bus.alu_carryout != gold_carry) ||
                          (bus.alu_zero != gold_zero);
        rsp_last_q     <= !sweep_q || (sel_q == OP_DEC);
      end

      if (rsp_fire && rsp_mismatch_q && (err_q != ERR_MAX))
        err_q <= err_q + ERR_W'(1);
    end
  end

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_sel      = sel_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_sel      = rsp_sel_q;
  assign bus.rsp_mismatch = rsp_mismatch_q;
  assign bus.rsp_last     = rsp_last_q;
  assign bus.err_count    = err_q;

endmodule

// File: tb/tb_alu_seq_checker.sv
// Directed bench for alu_seq_checker: a behavioural ALU stub with fault
// knobs sits on the alu_* side, each scenario task checks its own results.
module tb_alu_seq_checker;

  logic clk;
  logic rst;
  logic fault_bit0;
  logic force_bad;
  int   errors;
  int   checks;

  logic [3:0] stub_res;
  logic       stub_c;
  logic       stub_z;

  logic [3:0] exp_sweep [8] = '{4'h4, 4'h2, 4'h1, 4'h3, 4'h2, 4'hC, 4'h4, 4'h2};
  logic [3:0] exp_fault [8] = '{4'h4, 4'h2, 4'h0, 4'h2, 4'h2, 4'hC, 4'h4, 4'h2};
  logic       exp_mm    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  alu_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus ();

  alu_seq_checker #(.WIDTH(4), .SETTLE(1), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU with a stuck-at-0 result bit and a zero-flag inverter.
  always_comb begin
    stub_res = 4'h0;
    stub_c   = 1'b0;
    case (bus.alu_sel)
      3'd0: {stub_c, stub_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd1: begin stub_res = bus.alu_a - bus.alu_b; stub_c = bus.alu_a < bus.alu_b; end
      3'd2: stub_res = bus.alu_a & bus.alu_b;
      3'd3: stub_res = bus.alu_a | bus.alu_b;
      3'd4: stub_res = bus.alu_a ^ bus.alu_b;
      3'd5: stub_res = ~bus.alu_a;
      3'd6: begin stub_res = bus.alu_a + 4'd1; stub_c = (bus.alu_a == 4'hF); end
      default: begin stub_res = bus.alu_a - 4'd1; stub_c = (bus.alu_a == 4'h0); end
    endcase
    if (fault_bit0) stub_res[0] = 1'b0;
    stub_z = (stub_res == 4'h0);
    if (force_bad) stub_z = ~stub_z;
  end

  assign bus.alu_result   = stub_res;
  assign bus.alu_carryout = stub_c;
  assign bus.alu_zero     = stub_z;

  task automatic send_cmd(input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] sel, input logic sweep);
    bit ok;
    ok = 1'b0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    bus.cmd_sweep = sweep;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (ok) @(posedge clk);
    else begin errors++; $display("[TB] FAIL cmd_accept: ready=%0b required 1 within 20 cycles", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rsp_timeout: rsp_valid=%0b required 1 within 40 cycles", bus.rsp_valid); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd_ready: got %0b want 0", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid: got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0 || bus.alu_sel !== 3'h0) begin errors++; $display("[TB] FAIL rst_alu: got a=%0h b=%0h sel=%0h want 0", bus.alu_a, bus.alu_b, bus.alu_sel); end
    checks++; if (bus.err_count !== 8'h0) begin errors++; $display("[TB] FAIL rst_err: got %0d want 0", bus.err_count); end
    rst = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %0b want 1", bus.cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b0;
    send_cmd(4'h3, 4'h1, 3'd0, 1'b0);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_ready: got %0b want 0", bus.cmd_ready); end
    checks++; if (bus.alu_a !== 4'h3 || bus.alu_b !== 4'h1 || bus.alu_sel !== 3'd0) begin errors++; $display("[TB] FAIL single_alu_drive: got a=%0h b=%0h sel=%0h want 3 1 0", bus.alu_a, bus.alu_b, bus.alu_sel); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: rsp_valid=%0b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_result !== 4'h4 || bus.rsp_carry !== 1'b0 || bus.rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL single_data: got r=%0h c=%0b z=%0b want 4 0 0", bus.rsp_result, bus.rsp_carry, bus.rsp_zero); end
    checks++; if (bus.rsp_mismatch !== 1'b0 || bus.rsp_last !== 1'b1 || bus.rsp_sel !== 3'd0) begin errors++; $display("[TB] FAIL single_flags: got mm=%0b last=%0b sel=%0h want 0 1 0", bus.rsp_mismatch, bus.rsp_last, bus.rsp_sel); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got valid=%0b ready=%0b want 0 1", bus.rsp_valid, bus.cmd_ready); end
  endtask

  task automatic test_overflow();
    bus.rsp_ready = 1'b0;
    send_cmd(4'hF, 4'h1, 3'd0, 1'b0);
    wait_rsp();
    checks++; if (bus.rsp_result !== 4'h0 || bus.rsp_carry !== 1'b1 || bus.rsp_zero !== 1'b1) begin errors++; $display("[TB] FAIL add_overflow: got r=%0h c=%0b z=%0b want 0 1 1", bus.rsp_result, bus.rsp_carry, bus.rsp_zero); end
    checks++; if (bus.rsp_mismatch !== 1'b0) begin errors++; $display("[TB] FAIL add_overflow_mm: got %0b want 0", bus.rsp_mismatch); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    send_cmd(4'h0, 4'h5, 3'd7, 1'b0);
    wait_rsp();
    checks++; if (bus.rsp_result !== 4'hF || bus.rsp_carry !== 1'b1 || bus.rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL dec_underflow: got r=%0h c=%0b z=%0b want F 1 0", bus.rsp_result, bus.rsp_carry, bus.rsp_zero); end
    checks++; if (bus.rsp_mismatch !== 1'b0 || bus.rsp_sel !== 3'd7) begin errors++; $display("[TB] FAIL dec_underflow_flags: got mm=%0b sel=%0h want 0 7", bus.rsp_mismatch, bus.rsp_sel); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_sweep();
    int n;
    int first;
    int lastc;
    n = 0; first = 0; lastc = 0;
    bus.rsp_ready = 1'b1;
    send_cmd(4'h3, 4'h1, 3'd5, 1'b1);
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_sel !== 3'(n)) begin errors++; $display("[TB] FAIL sweep_sel[%0d]: got %0d want %0d", n, bus.rsp_sel, n); end
        checks++; if (bus.rsp_result !== exp_sweep[n]) begin errors++; $display("[TB] FAIL sweep_result[%0d]: got %0h want %0h", n, bus.rsp_result, exp_sweep[n]); end
        checks++; if (bus.rsp_carry !== 1'b0 || bus.rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL sweep_cz[%0d]: got c=%0b z=%0b want 0 0", n, bus.rsp_carry, bus.rsp_zero); end
        checks++; if (bus.rsp_last !== (n == 7)) begin errors++; $display("[TB] FAIL sweep_last[%0d]: got %0b want %0b", n, bus.rsp_last, n == 7); end
        checks++; if (bus.rsp_mismatch !== 1'b0) begin errors++; $display("[TB] FAIL sweep_mm[%0d]: got %0b want 0", n, bus.rsp_mismatch); end
        if (n == 0) first = cyc;
        lastc = cyc;
        n++;
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("[TB] FAIL sweep_count: got %0d want 8", n); end
    checks++; if (lastc - first !== 14) begin errors++; $display("[TB] FAIL sweep_throughput: span %0d cycles want 14", lastc - first); end
    checks++; if (bus.err_count !== 8'd0 || bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL sweep_end: got err=%0d ready=%0b want 0 1", bus.err_count, bus.cmd_ready); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    send_cmd(4'h3, 4'h1, 3'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_rsp();
      checks++; if (bus.rsp_sel !== 3'(k) || bus.rsp_result !== exp_sweep[k]) begin errors++; $display("[TB] FAIL bp_rsp[%0d]: got sel=%0d r=%0h want %0d %0h", k, bus.rsp_sel, bus.rsp_result, k, exp_sweep[k]); end
      if (k == 3) begin
        bus.cmd_a = 4'hA;
        bus.cmd_valid = 1'b1;
        repeat (5) begin
          @(negedge clk);
          checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h3 || bus.rsp_sel !== 3'd3) begin errors++; $display("[TB] FAIL bp_frozen: got v=%0b r=%0h sel=%0d want 1 3 3", bus.rsp_valid, bus.rsp_result, bus.rsp_sel); end
          checks++; if (bus.cmd_ready !== 1'b0 || bus.alu_sel !== 3'd3 || bus.alu_a !== 4'h3) begin errors++; $display("[TB] FAIL bp_hold: got ready=%0b alu_sel=%0d alu_a=%0h want 0 3 3", bus.cmd_ready, bus.alu_sel, bus.alu_a); end
        end
        bus.cmd_valid = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.err_count !== 8'd0) begin errors++; $display("[TB] FAIL bp_end: got ready=%0b err=%0d want 1 0", bus.cmd_ready, bus.err_count); end
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b0;
    send_cmd(4'h5, 4'h3, 3'd2, 1'b0);
    wait_rsp();
    checks++; if (bus.rsp_result !== 4'h1 || bus.rsp_last !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got r=%0h last=%0b want 1 1", bus.rsp_result, bus.rsp_last); end
    bus.cmd_a = 4'h9; bus.cmd_b = 4'h6; bus.cmd_sel = 3'd3; bus.cmd_sweep = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.alu_a !== 4'h5) begin errors++; $display("[TB] FAIL b2b_same_edge: got v=%0b ready=%0b alu_a=%0h want 0 1 5", bus.rsp_valid, bus.cmd_ready, bus.alu_a); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b0 || bus.alu_a !== 4'h9 || bus.alu_sel !== 3'd3) begin errors++; $display("[TB] FAIL b2b_accept: got ready=%0b alu_a=%0h sel=%0d want 0 9 3", bus.cmd_ready, bus.alu_a, bus.alu_sel); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'hF || bus.rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second: got v=%0b r=%0h z=%0b want 1 F 0", bus.rsp_valid, bus.rsp_result, bus.rsp_zero); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_fault();
    int n;
    n = 0;
    fault_bit0 = 1'b1;
    bus.rsp_ready = 1'b1;
    send_cmd(4'h3, 4'h1, 3'd0, 1'b1);
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_result !== exp_fault[n]) begin errors++; $display("[TB] FAIL fault_result[%0d]: got %0h want %0h", n, bus.rsp_result, exp_fault[n]); end
        checks++; if (bus.rsp_mismatch !== exp_mm[n]) begin errors++; $display("[TB] FAIL fault_mm[%0d]: got %0b want %0b", n, bus.rsp_mismatch, exp_mm[n]); end
        n++;
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    fault_bit0 = 1'b0;
    checks++; if (n !== 8 || bus.err_count !== 8'd2) begin errors++; $display("[TB] FAIL fault_err_count: got n=%0d err=%0d want 8 2", n, bus.err_count); end
  endtask

  task automatic test_saturation();
    force_bad = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_cmd(4'h5, 4'h2, 3'd0, 1'b0);
      wait_rsp();
      if (i == 299) begin
        checks++; if (bus.rsp_mismatch !== 1'b1 || bus.rsp_result !== 4'h7) begin errors++; $display("[TB] FAIL sat_rsp: got mm=%0b r=%0h want 1 7", bus.rsp_mismatch, bus.rsp_result); end
      end
      @(negedge clk);
      if (i == 99) begin
        checks++; if (bus.err_count !== 8'd102) begin errors++; $display("[TB] FAIL sat_mid: got %0d want 102", bus.err_count); end
      end
    end
    bus.rsp_ready = 1'b0;
    force_bad = 1'b0;
    checks++; if (bus.err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_final: got %0d want 255", bus.err_count); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    n = 0;
    bus.rsp_ready = 1'b1;
    send_cmd(4'h3, 4'h1, 3'd0, 1'b1);
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      if (bus.rsp_valid) n++;
      @(negedge clk);
    end
    checks++; if (n !== 3) begin errors++; $display("[TB] FAIL mid_handshakes: got %0d want 3", n); end
    rst = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_hs: got ready=%0b valid=%0b want 0 0", bus.cmd_ready, bus.rsp_valid); end
    checks++; if (bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0 || bus.alu_sel !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_alu: got a=%0h b=%0h sel=%0d want 0", bus.alu_a, bus.alu_b, bus.alu_sel); end
    checks++; if (bus.err_count !== 8'd0 || bus.rsp_result !== 4'h0 || bus.rsp_sel !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_rsp: got err=%0d r=%0h sel=%0d want 0", bus.err_count, bus.rsp_result, bus.rsp_sel); end
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_release_ready: got %0b want 1", bus.cmd_ready); end
    @(negedge clk);
    send_cmd(4'h2, 4'h6, 3'd1, 1'b0);
    wait_rsp();
    checks++; if (bus.rsp_result !== 4'hC || bus.rsp_carry !== 1'b1 || bus.rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_data: got r=%0h c=%0b z=%0b want C 1 0", bus.rsp_result, bus.rsp_carry, bus.rsp_zero); end
    checks++; if (bus.rsp_sel !== 3'd1 || bus.rsp_last !== 1'b1 || bus.rsp_mismatch !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_flags: got sel=%0d last=%0b mm=%0b want 1 1 0", bus.rsp_sel, bus.rsp_last, bus.rsp_mismatch); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++; if (bus.err_count !== 8'd0 || bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_end: got err=%0d ready=%0b want 0 1", bus.err_count, bus.cmd_ready); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    fault_bit0 = 1'b0;
    force_bad = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 4'h0;
    bus.cmd_b = 4'h0;
    bus.cmd_sel = 3'd0;
    bus.cmd_sweep = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_sweep();
    test_backpressure();
    test_back_to_back();
    test_fault();
    test_saturation();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_checker.md
# alu_seq_checker

Sequencing checker that sits on the far side of the 4-bit `alu` block. It accepts operand/opcode commands over a valid/ready interface and drives the ALU's `A`/`B`/`sel` inputs from registers. After a settle time it captures `result`/`carryout`/`zero`, compares them against an internal golden model, and returns the captured values plus a mismatch flag over a valid/ready response interface. A sweep mode walks all eight opcodes for one operand pair, so the block doubles as an on-chip self-test engine for the ALU.

## Interface
- `WIDTH`, 4: operand/result width; matches the ALU.
- `SETTLE`, 1: cycles `alu_*` are held before capture; legal range 1..15.
- `ERR_W`, 8: width of the saturating error counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block accepts a command.
- `cmd_a` in WIDTH: operand A.
- `cmd_b` in WIDTH: operand B.
- `cmd_sel` in 3: opcode; ignored when `cmd_sweep`=1.
- `cmd_sweep` in 1: run opcodes 000..111 in order.
- `alu_a` out WIDTH: registered drive to ALU `A`.
- `alu_b` out WIDTH: registered drive to ALU `B`.
- `alu_sel` out 3: registered drive to ALU `sel`.
- `alu_result` in WIDTH: from ALU.
- `alu_carryout` in 1: from ALU.
- `alu_zero` in 1: from ALU.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out WIDTH: captured ALU result.
- `rsp_carry` out 1: captured ALU carry.
- `rsp_zero` out 1: captured ALU zero.
- `rsp_sel` out 3: opcode of this response.
- `rsp_mismatch` out 1: captured values differ from the golden model.
- `rsp_last` out 1: final response of the command.
- `err_count` out ERR_W: total mismatches, saturating.

## Operation
- **States:**
  - IDLE: `cmd_ready`=1. A `cmd_valid` handshake latches `a`, `b`, `sweep`, and the opcode (`cmd_sel`, or 000 if sweep), loads the `alu_*` registers, and moves to DRIVE.
  - DRIVE: the settle counter counts SETTLE cycles. On the last cycle, the ALU outputs and golden values are captured into the `rsp_*` registers and the state moves to RESP.
  - RESP: `rsp_valid`=1. On handshake: if sweep=1 and opcode≠111, opcode+1 is loaded into `alu_sel` and the state moves to DRIVE; otherwise the state moves to IDLE.
- **Golden model:**
  - 000: A+B, carry = bit WIDTH of the sum.
  - 001: A−B, carry = borrow, i.e. 1 when A<B.
  - 010: A&B; 011: A|B; 100: A^B; 101: ~A. Carry=0 for all four.
  - 110: A+1, carry=1 when A=all-ones.
  - 111: A−1, carry=1 when A=0.
  - zero = (result==0), for every opcode.
- **Mismatch:** `rsp_mismatch` = any difference in result, carry, or zero.
- **err_count:** increments on each `rsp_valid`&`rsp_ready` handshake with `rsp_mismatch`=1; saturates at 2^ERR_W−1.
- **rsp_last:** 1 for a non-sweep response, and for the opcode-111 response of a sweep.
- **cmd_ready:** 0 outside IDLE. Commands presented while busy are not accepted; the source holds them.

## Timing
- **Reset values:** all outputs are 0, including `cmd_ready` (0 while `rst`=1); state is IDLE.
- **Reset deassertion:** `cmd_ready`=1 in the first cycle after `rst` falls.
- **Latency:** command accepted at edge N → `rsp_valid`=1 after edge N+SETTLE. ALU inputs change only at the accept edge or at a response handshake edge.
- **Response stability:** `rsp_*` are stable while `rsp_valid`=1 and `rsp_ready`=0, with no bound on how long backpressure lasts.
- **Sweep throughput:** with `rsp_ready` tied high, one response per SETTLE+1 cycles; 8 responses in total.
- **Reset mid-operation:** immediately returns to IDLE and clears `rsp_valid`, `err_count` and the `alu_*` registers. A partially completed sweep is abandoned, not resumed.
- **Accept after last:** the response handshake with `rsp_last`=1 moves to IDLE. A new command can be accepted on the following edge, not the same edge.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants: ADD, SUB, AND, OR, XOR, NOT, INC, DEC;
  - the FSM state enum: IDLE, DRIVE, RESP;
  - the default WIDTH.
- Sub-module `alu_ref_model`: purely combinational golden model taking a, b, sel and producing result, carry, zero. It is instantiated once here and reused by benches.

## Test plan
- **Single op:** A=0011, B=0001, sel=000, SETTLE=1 → `rsp_valid` after edge N+1; result 0100, carry 0, zero 0, mismatch 0, last 1.
- **Sweep:** A=0011, B=0001, `rsp_ready`=1 → 8 responses with results 4,2,1,3,2,C,4,2; `rsp_sel` 0..7; `rsp_last` only on sel 7; `err_count`=0.
- **Add overflow:** A=1111, B=0001, sel=000 → result 0000, carry 1, zero 1. Also A=0000, sel=111 → result 1111, carry 1.
- **Backpressure:** `rsp_ready`=0 for 5 cycles mid-sweep → `rsp_*` frozen, `cmd_ready`=0, `alu_sel` unchanged; the sweep resumes on the handshake.
- **Fault injection:** bench ALU stub with result bit0 stuck at 0, then a sweep on A=3, B=1 → mismatch on sel 010 and 011 (results 1 and 3); `err_count`=2. Separately, 300 forced mismatches → `err_count` saturates at 255.
- **Reset mid-sweep:** assert `rst` after the 3rd handshake → outputs 0 asynchronously; `cmd_ready`=1 in the first cycle after release; a new single command completes normally.
